// File: rtl/brisc_pkg.sv
// Shared widths and the memory-arbiter state encoding for the brisc memory subsystem.
package brisc_pkg;
    localparam int ADDRESS_WIDTH = 32;
    localparam int LINE_WIDTH    = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } mem_arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and main-memory handshake signals around mem_arbiter.
// master = requesters + memory model side, slave = the arbiter itself.
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = brisc_pkg::ADDRESS_WIDTH,
    parameter int LINE_WIDTH    = brisc_pkg::LINE_WIDTH
);
    import brisc_pkg::*;

    logic                     ic_req_i;
    logic [ADDRESS_WIDTH-1:0] ic_addr_i;
    logic                     ic_resp_o;
    logic [LINE_WIDTH-1:0]    ic_rdata_o;
    logic                     dc_req_i;
    logic                     dc_we_i;
    logic [ADDRESS_WIDTH-1:0] dc_addr_i;
    logic [LINE_WIDTH-1:0]    dc_wdata_i;
    logic                     dc_resp_o;
    logic [LINE_WIDTH-1:0]    dc_rdata_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [ADDRESS_WIDTH-1:0] mem_addr_o;
    logic [LINE_WIDTH-1:0]    mem_wdata_o;
    logic                     mem_resp_i;
    logic [LINE_WIDTH-1:0]    mem_rdata_i;

    modport master (
        output ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
               mem_resp_i, mem_rdata_i,
        input  ic_resp_o, ic_rdata_o, dc_resp_o, dc_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  ic_req_i, ic_addr_i, dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
               mem_resp_i, mem_rdata_i,
        output ic_resp_o, ic_rdata_o, dc_resp_o, dc_rdata_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between I-side and D-side requests.
// MEM_ARB_RR_EN selects round-robin tie-break; otherwise D always beats I.
module mem_arb_picker
    import brisc_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_d,
    output logic grant_valid,
    output logic grant_d
);
    assign grant_valid = ic_req | dc_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the side that was not granted last time wins.
    assign grant_d = (ic_req && dc_req) ? ~last_d : dc_req;
`else
    logic unused_last_d;
    assign unused_last_d = last_d;
    assign grant_d       = dc_req;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache fills and D-cache fills/writebacks.
// Build option MEM_ARB_RR_EN enables round-robin tie-breaking (default: D over I).
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = brisc_pkg::ADDRESS_WIDTH,
    parameter int LINE_WIDTH    = brisc_pkg::LINE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    import brisc_pkg::*;

    mem_arb_state_e           state_q, state_d;
    logic                     grant_d_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0]    wdata_q;
    logic [LINE_WIDTH-1:0]    rdata_q;
    logic                     pick_valid, pick_d, last_d;

    mem_arb_picker u_picker (
        .ic_req      (bus.ic_req_i),
        .dc_req      (bus.dc_req_i),
        .last_d      (last_d),
        .grant_valid (pick_valid),
        .grant_d     (pick_d)
    );

`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    // Reset to 1 so the very first tie goes to the I side.
    always_ff @(posedge clk) begin
        if (reset)
            last_d_q <= 1'b1;
        else if (state_q == ARB_IDLE && pick_valid)
            last_d_q <= pick_d;
    end
    assign last_d = last_d_q;
`else
    assign last_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (pick_valid) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT:  if (bus.mem_resp_i) state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Command is captured once at grant, so later requester wiggles cannot leak through.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (state_q == ARB_IDLE && pick_valid) begin
                grant_d_q <= pick_d;
                we_q      <= pick_d & bus.dc_we_i;
                addr_q    <= pick_d ? bus.dc_addr_i : bus.ic_addr_i;
                wdata_q   <= pick_d ? bus.dc_wdata_i : '0;
            end
            if (state_q == ARB_WAIT && bus.mem_resp_i)
                rdata_q <= bus.mem_rdata_i;
        end
    end

    always_comb begin
        bus.mem_req_o = 1'b0;
        bus.mem_we_o  = 1'b0;
        bus.ic_resp_o = 1'b0;
        bus.dc_resp_o = 1'b0;
        case (state_q)
            ARB_ISSUE: begin
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = we_q;
            end
            ARB_RESP: begin
                bus.ic_resp_o = ~grant_d_q;
                bus.dc_resp_o = grant_d_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.ic_rdata_o  = rdata_q;
    assign bus.dc_rdata_o  = rdata_q;

`ifndef SYNTHESIS
    a_no_resp_in_issue: assert property (@(posedge clk) disable iff (reset)
        (state_q == ARB_ISSUE) |-> !bus.mem_resp_i);
    a_ic_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.ic_req_i && $past(bus.ic_req_i) && !bus.ic_resp_o) |-> $stable(bus.ic_addr_i));
    a_dc_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.dc_req_i && $past(bus.dc_req_i) && !bus.dc_resp_o)
        |-> ($stable(bus.dc_addr_i) && $stable(bus.dc_we_i) && $stable(bus.dc_wdata_i)));
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, random traffic.
module tb_mem_arbiter;
    import brisc_pkg::*;

    typedef logic [31:0]  addr_t;
    typedef logic [127:0] line_t;

    typedef struct {
        bit    side;
        bit    we;
        addr_t addr;
        line_t wdata;
        int    lat;
        int    exp_req_dly;
        int    exp_resp_dly;
        line_t exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();
    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t pattern(input addr_t a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    // Reference view of memory contents as seen by completed transactions.
    line_t ref_mem [addr_t];
    function automatic line_t ref_line(input addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
    endfunction

    // Memory model: answers each command after a programmable latency.
    line_t env_mem [addr_t];
    int    mem_lat  = 3;
    bit    mem_rand = 0;
    bit    mem_auto = 1;
    logic  auto_resp = 1'b0, man_resp = 1'b0;
    line_t auto_rdata = '0;
    assign bus.mem_resp_i  = auto_resp | man_resp;
    assign bus.mem_rdata_i = auto_rdata;

    initial begin : mem_model
        int    mcnt;
        addr_t pend;
        mcnt = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            auto_resp = 1'b0;
            if (!mem_auto) mcnt = 0;
            else if (bus.mem_req_o) begin
                if (bus.mem_we_o) env_mem[bus.mem_addr_o] = bus.mem_wdata_o;
                mcnt = mem_rand ? int'($urandom_range(1, 6)) : mem_lat;
                pend = bus.mem_addr_o;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    auto_resp  = 1'b1;
                    auto_rdata = env_mem.exists(pend) ? env_mem[pend] : pattern(pend);
                end
            end
        end
    end

    // Requests as the arbiter saw them at the last rising edge.
    logic s_ic = 1'b0, s_dc = 1'b0;
    always @(posedge clk) begin
        s_ic <= bus.ic_req_i;
        s_dc <= bus.dc_req_i;
    end

    addr_t cur_i_addr = '0, cur_d_addr = '0;
    bit    cur_d_we = 0;
    line_t cur_d_wdata = '0;
    int    n_memreq = 0, n_ic_resp = 0, n_dc_resp = 0, last_req_cyc = 0;
    bit    grant_log [$];

    // Monitor: every memory command must go to the side the arbitration rule picks.
    initial begin : monitor
        bit model_last_d, prev_req, exp_d, win_d;
        model_last_d = 1;
        prev_req     = 0;
        forever begin
            @(negedge clk);
            if (reset) model_last_d = 1;
            else if (bus.mem_req_o) begin
                n_memreq++;
                last_req_cyc = cyc;
                chk("mem_req_single_cycle", prev_req, 0);
                chk("grant_had_request", s_ic | s_dc, 1);
`ifdef MEM_ARB_RR_EN
                exp_d = (s_ic && s_dc) ? !model_last_d : s_dc;
`else
                exp_d = s_dc;
`endif
                win_d = bus.mem_addr_o[13];
                chk("grant_side", win_d, exp_d);
                model_last_d = exp_d;
                grant_log.push_back(win_d);
                if (exp_d) begin
                    chk("mem_addr_d", bus.mem_addr_o, cur_d_addr);
                    chk("mem_we_d", bus.mem_we_o, cur_d_we);
                    if (cur_d_we) chk("mem_wdata_d", bus.mem_wdata_o, cur_d_wdata);
                end else begin
                    chk("mem_addr_i", bus.mem_addr_o, cur_i_addr);
                    chk("mem_we_i", bus.mem_we_o, 0);
                end
            end
            if (bus.ic_resp_o) n_ic_resp++;
            if (bus.dc_resp_o) n_dc_resp++;
            if (bus.ic_resp_o || bus.dc_resp_o)
                chk("resp_exclusive", bus.ic_resp_o & bus.dc_resp_o, 0);
            prev_req = bus.mem_req_o;
        end
    end

    // One requester transaction, started at a falling edge; waits (bounded) for its response.
    task automatic txn(input bit side, input bit we, input addr_t addr, input line_t wdata,
                       input bit keep, output bit got, output line_t rdata,
                       output int t0, output int tr);
        t0 = cyc;
        if (side) begin
            cur_d_addr = addr; cur_d_we = we; cur_d_wdata = wdata;
            bus.dc_req_i = 1'b1; bus.dc_we_i = we; bus.dc_addr_i = addr; bus.dc_wdata_i = wdata;
        end else begin
            cur_i_addr = addr;
            bus.ic_req_i = 1'b1; bus.ic_addr_i = addr;
        end
        got = 0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            got = side ? bus.dc_resp_o : bus.ic_resp_o;
        end
        tr    = cyc;
        rdata = side ? bus.dc_rdata_o : bus.ic_rdata_o;
        chk(side ? "dc_resp_seen" : "ic_resp_seen", got, 1);
        if (got && we) ref_mem[addr] = wdata;
        if (!keep) begin
            if (side) bus.dc_req_i = 1'b0;
            else      bus.ic_req_i = 1'b0;
        end
    endtask

    // gap < 0 means random idle gap (0..3) between requests.
    task automatic run_side(input bit side, input int n, input int gap, input bit rnd);
        bit    got, we, keep;
        addr_t a;
        line_t wd, rd;
        int    t0, tr, g;
        for (int k = 0; k < n; k++) begin
            g  = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            we = side && rnd && ($urandom_range(0, 1) == 1);
            a  = side ? 32'h2000 + 32'(16 * (rnd ? $urandom_range(0, 3) : k))
                      : 32'h1000 + 32'(16 * (rnd ? $urandom_range(0, 15) : k));
            wd = {$urandom, $urandom, $urandom, $urandom};
            keep = (g == 0) && (k < n - 1);
            txn(side, we, a, wd, keep, got, rd, t0, tr);
            if (got && !we) chk(side ? "dc_rdata" : "ic_rdata", rd, ref_line(a));
            if (!keep) repeat (g) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ic_req_i = 1'b0;
        bus.dc_req_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    vec_t  tbl [5];
    bit    exp_order [$];

    initial begin : main
        bit    got;
        line_t rd;
        int    t0, tr, base_req, base_ic, base_dc;

        reset = 1'b1;
        bus.ic_req_i = 0; bus.ic_addr_i = '0;
        bus.dc_req_i = 0; bus.dc_we_i = 0; bus.dc_addr_i = '0; bus.dc_wdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", bus.mem_req_o, 0);
        chk("rst_mem_we", bus.mem_we_o, 0);
        chk("rst_ic_resp", bus.ic_resp_o, 0);
        chk("rst_dc_resp", bus.dc_resp_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed single transactions: req->mem_req is 1 cycle, mem_req->resp is lat+1.
        tbl[0] = '{0, 0, 32'h1000, '0, 5, 1, 6, pattern(32'h1000)};
        tbl[1] = '{1, 1, 32'h2000, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 3, 1, 4, '0};
        tbl[2] = '{1, 0, 32'h2000, '0, 1, 1, 2, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D};
        tbl[3] = '{0, 0, 32'h1010, '0, 2, 1, 3, pattern(32'h1010)};
        tbl[4] = '{1, 0, 32'h2010, '0, 4, 1, 5, pattern(32'h2010)};
        for (int i = 0; i < 5; i++) begin
            base_ic = n_ic_resp; base_dc = n_dc_resp;
            mem_lat = tbl[i].lat;
            txn(tbl[i].side, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, got, rd, t0, tr);
            chk("tbl_req_latency", last_req_cyc - t0, tbl[i].exp_req_dly);
            chk("tbl_resp_latency", tr - last_req_cyc, tbl[i].exp_resp_dly);
            if (!tbl[i].we) chk("tbl_rdata", rd, tbl[i].exp_rdata);
            repeat (2) @(negedge clk);
            chk("tbl_ic_resp_count", n_ic_resp - base_ic, tbl[i].side ? 0 : 1);
            chk("tbl_dc_resp_count", n_dc_resp - base_dc, tbl[i].side ? 1 : 0);
        end

        // Simultaneous single requests from both sides.
        do_reset();
        mem_lat = 2;
        grant_log.delete();
        fork
            run_side(0, 1, 0, 0);
            run_side(1, 1, 0, 0);
        join
        repeat (2) @(negedge clk);
        chk("tie_grant_count", grant_log.size(), 2);
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1};
`else
        exp_order = '{1, 0};
`endif
        for (int k = 0; k < 2 && k < grant_log.size(); k++) chk("tie_order", grant_log[k], exp_order[k]);

        // Both sides held for four back-to-back transactions each.
        do_reset();
        grant_log.delete();
        exp_order.delete();
        fork
            run_side(0, 4, 0, 0);
            run_side(1, 4, 0, 0);
        join
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_order.push_back(k % 2 == 1);
`else
            exp_order.push_back(k < 4);
`endif
        end
        chk("held_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("held_order", grant_log[k], exp_order[k]);

        // Reset while waiting on memory; a late response must be dropped.
        mem_auto = 0;
        base_ic = n_ic_resp; base_dc = n_dc_resp;
        cur_i_addr = 32'h1020;
        bus.ic_addr_i = 32'h1020; bus.ic_req_i = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.mem_req_o;
        end
        chk("rstwait_mem_req_seen", got, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.ic_req_i = 1'b0;
        @(negedge clk);
        chk("rstwait_addr_cleared", bus.mem_addr_o, 0);
        reset = 1'b0;
        @(negedge clk);
        man_resp = 1'b1;
        @(negedge clk);
        man_resp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstwait_no_ic_resp", bus.ic_resp_o, 0);
            chk("rstwait_no_mem_req", bus.mem_req_o, 0);
        end
        chk("rstwait_resp_count", (n_ic_resp - base_ic) + (n_dc_resp - base_dc), 0);
        mem_auto = 1;
        mem_lat = 3;
        txn(0, 0, 32'h1030, '0, 0, got, rd, t0, tr);
        chk("rstwait_next_rdata", rd, pattern(32'h1030));
        @(negedge clk);

        // Back-to-back I requests: second raised one cycle after the response.
        base_req = n_memreq; base_ic = n_ic_resp;
        run_side(0, 3, 1, 0);
        repeat (3) @(negedge clk);
        chk("b2b_mem_req_count", n_memreq - base_req, 3);
        chk("b2b_ic_resp_count", n_ic_resp - base_ic, 3);

        // Random mixed traffic with random memory latency.
        mem_rand = 1;
        base_req = n_memreq; base_ic = n_ic_resp; base_dc = n_dc_resp;
        fork
            run_side(0, 20, -1, 1);
            run_side(1, 20, -1, 1);
        join
        repeat (3) @(negedge clk);
        chk("rand_mem_req_count", n_memreq - base_req, 40);
        chk("rand_ic_resp_count", n_ic_resp - base_ic, 20);
        chk("rand_dc_resp_count", n_dc_resp - base_dc, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
